// File: rtl/fifo_rd_streamer.sv
// Turns a registered-output synchronous FIFO read port into a valid/ready stream.
// A 2-entry skid buffer absorbs the 1-clk read latency so throughput is 1 beat/clk.
module fifo_rd_streamer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic              fifo_underflow,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              underflow_err,
  output logic              idle
);

  logic [1:0]        occ;
  logic              infl;
  logic [DATA_W-1:0] buf_head;
  logic [DATA_W-1:0] buf_tail;
  logic              pop;
  logic [2:0]        level;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_head;
  assign pop     = m_valid && m_ready;

  // Words held or arriving after this edge; a read is safe only if a slot stays free.
  assign level      = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
  assign fifo_rd_en = !rst && enable && !fifo_empty && (level < 3'd2);
  assign idle       = (occ == 2'd0) && !infl && !fifo_rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl <= 1'b0;
    end else begin
      infl <= fifo_rd_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
    end else begin
      case ({infl, pop})
        2'b10: begin
          if (occ == 2'd0) buf_head <= fifo_data;
          else             buf_tail <= fifo_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf_head <= buf_tail;
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            buf_head <= buf_tail;
            buf_tail <= fifo_data;
          end else begin
            buf_head <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (cnt_clr) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_err <= 1'b0;
    end else if (fifo_underflow) begin
      underflow_err <= 1'b1;
    end
  end

  // A capture into a full buffer with no pop would silently drop a word.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(infl && !pop && (occ == 2'd2)));
  a_occ_range: assert property (@(posedge clk) disable iff (rst) occ != 2'd3);

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: behavioural FIFO model plus a scoreboard of written words.
module tb_fifo_rd_streamer;
  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          cnt_clr;
  logic [CW-1:0] beat_cnt;
  logic          underflow_err;
  logic          idle;

  fifo_rd_streamer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .cnt_clr(cnt_clr),
    .beat_cnt(beat_cnt), .underflow_err(underflow_err), .idle(idle)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:1023];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          uf_reg;
  logic          uf_force = 1'b0;

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_underflow = uf_reg | uf_force;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= '0;
      uf_reg    <= 1'b0;
    end else begin
      uf_reg <= fifo_rd_en && fifo_empty;
      if (fifo_rd_en && !fifo_empty) begin
        fifo_data <= mem[rd_ptr % 1024];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  logic [DW-1:0] sb [$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            pop_total = 0;
  int            rd_total = 0;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] exp_w;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (fifo_empty) begin
        n_cmp++;
        if (fifo_rd_en !== 1'b0) begin
          n_err++;
          $display("FAIL rd_while_empty: fifo_rd_en=%b required 0 at %0t", fifo_rd_en, $time);
        end
      end
      if (hold_pend) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== hold_data) begin
          n_err++;
          $display("FAIL stream_hold: m_valid=%b m_data=%h required 1/%h at %0t",
                   m_valid, m_data, hold_data, $time);
        end
      end
      if (m_valid && m_ready) begin
        pop_total++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra_beat: m_data=%h required no beat at %0t", m_data, $time);
        end else begin
          exp_w = sb.pop_front();
          if (m_data !== exp_w) begin
            n_err++;
            $display("FAIL sb_data: m_data=%h required %h at %0t", m_data, exp_w, $time);
          end
        end
      end
      if (fifo_rd_en) rd_total++;
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr = wr_ptr + 1;
    sb.push_back(w);
  endtask

  task automatic wait_drain(input int bound, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (sb.size() == 0 && idle) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0; cnt_clr = 1'b0;
    step(); step();
    n_cmp += 6;
    if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b required 0", fifo_rd_en); end
    if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
    if (m_data !== '0) begin n_err++; $display("FAIL reset_m_data: got %h required 0", m_data); end
    if (beat_cnt !== '0) begin n_err++; $display("FAIL reset_beat_cnt: got %0d required 0", beat_cnt); end
    if (underflow_err !== 1'b0) begin n_err++; $display("FAIL reset_uf_err: got %b required 0", underflow_err); end
    if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b required 1", idle); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_stream();
    int first_rd = -1, first_pop = -1, last_pop = -1, pops = 0;
    enable = 1'b0; m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #3;
      if (fifo_rd_en && first_rd < 0) first_rd = i;
      if (m_valid && m_ready) begin
        if (first_pop < 0) first_pop = i;
        last_pop = i;
        pops++;
      end
      step();
    end
    n_cmp += 5;
    if (first_pop - first_rd != 2) begin n_err++; $display("FAIL stream_latency: got %0d required 2", first_pop - first_rd); end
    if (pops != 8) begin n_err++; $display("FAIL stream_beats: got %0d required 8", pops); end
    if (last_pop - first_pop != 7) begin n_err++; $display("FAIL stream_back_to_back: span %0d required 7", last_pop - first_pop); end
    if (beat_cnt !== 4'd8) begin n_err++; $display("FAIL stream_beat_cnt: got %0d required 8", beat_cnt); end
    if (idle !== 1'b1) begin n_err++; $display("FAIL stream_idle: got %b required 1", idle); end
  endtask

  task automatic test_backpressure();
    int rd0;
    bit to;
    enable = 1'b0; m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    rd0 = rd_total;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) step();
    n_cmp += 3;
    if (rd_total - rd0 != 2) begin n_err++; $display("FAIL bp_reads: got %0d required 2", rd_total - rd0); end
    if (m_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b required 1", m_valid); end
    if (m_data !== 16'h0001) begin n_err++; $display("FAIL bp_data: got %h required 0001", m_data); end
    m_ready = 1'b1;
    wait_drain(100, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL bp_drain: timed out, %0d words outstanding required 0", sb.size()); end
  endtask

  task automatic test_random_ready();
    int p0;
    bit done = 1'b0;
    enable = 1'b0;
    p0 = pop_total;
    for (int i = 0; i < 200; i++) push_word(DW'($urandom));
    enable = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
      if (sb.size() == 0 && idle) done = 1'b1;
    end
    m_ready = 1'b1;
    n_cmp += 2;
    if (!done) begin n_err++; $display("FAIL rand_drain: timed out, %0d words outstanding required 0", sb.size()); end
    if (pop_total - p0 != 200) begin n_err++; $display("FAIL rand_beats: got %0d required 200", pop_total - p0); end
  endtask

  task automatic test_enable_drop();
    int rd0, p0;
    bit to;
    enable = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(16'hA000 + DW'(i));
    step();
    enable = 1'b1;
    step();
    step();
    enable = 1'b0; m_ready = 1'b1;
    rd0 = rd_total; p0 = pop_total;
    for (int i = 0; i < 10; i++) step();
    n_cmp += 4;
    if (rd_total != rd0) begin n_err++; $display("FAIL drop_no_reads: got %0d required 0", rd_total - rd0); end
    if (pop_total - p0 != 2) begin n_err++; $display("FAIL drop_drained: got %0d required 2", pop_total - p0); end
    if (idle !== 1'b1) begin n_err++; $display("FAIL drop_idle: got %b required 1", idle); end
    if (wr_ptr - rd_ptr != 2) begin n_err++; $display("FAIL drop_fifo_left: got %0d required 2", wr_ptr - rd_ptr); end
    enable = 1'b1;
    wait_drain(100, to);
    n_cmp++;
    if (to) begin n_err++; $display("FAIL drop_final_drain: timed out, %0d outstanding required 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    int p0;
    bit to;
    enable = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(16'hB000 + DW'(i));
    step();
    enable = 1'b1;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp += 6;
    if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL arst_rd_en: got %b required 0", fifo_rd_en); end
    if (m_valid !== 1'b0) begin n_err++; $display("FAIL arst_m_valid: got %b required 0", m_valid); end
    if (m_data !== '0) begin n_err++; $display("FAIL arst_m_data: got %h required 0", m_data); end
    if (beat_cnt !== '0) begin n_err++; $display("FAIL arst_beat_cnt: got %0d required 0", beat_cnt); end
    if (underflow_err !== 1'b0) begin n_err++; $display("FAIL arst_uf_err: got %b required 0", underflow_err); end
    if (idle !== 1'b1) begin n_err++; $display("FAIL arst_idle: got %b required 1", idle); end
    sb.delete();
    step();
    rst = 1'b0;
    p0 = pop_total;
    push_word(16'hC001); push_word(16'hC002); push_word(16'hC003);
    m_ready = 1'b1;
    wait_drain(100, to);
    n_cmp += 2;
    if (to) begin n_err++; $display("FAIL arst_restart: timed out, %0d outstanding required 0", sb.size()); end
    if (pop_total - p0 != 3) begin n_err++; $display("FAIL arst_beats: got %0d required 3", pop_total - p0); end
  endtask

  task automatic test_counter_and_underflow();
    int p0;
    bit to;
    bit seen = 1'b0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_cmp++;
    if (beat_cnt !== '0) begin n_err++; $display("FAIL clr_only: got %0d required 0", beat_cnt); end
    m_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 17; i++) push_word(16'hD000 + DW'(i));
    wait_drain(200, to);
    n_cmp += 2;
    if (to) begin n_err++; $display("FAIL wrap_drain: timed out, %0d outstanding required 0", sb.size()); end
    if (beat_cnt !== 4'd1) begin n_err++; $display("FAIL wrap_cnt: got %0d required 1", beat_cnt); end
    m_ready = 1'b0;
    push_word(16'hE001); push_word(16'hE002);
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (m_valid) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL clr_pop_setup: m_valid timed out, required 1"); end
    p0 = pop_total;
    m_ready = 1'b1; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_cmp += 2;
    if (beat_cnt !== '0) begin n_err++; $display("FAIL clr_with_pop: got %0d required 0", beat_cnt); end
    if (pop_total - p0 != 1) begin n_err++; $display("FAIL clr_pop_happened: got %0d required 1", pop_total - p0); end
    step();
    n_cmp++;
    if (beat_cnt !== 4'd1) begin n_err++; $display("FAIL cnt_after_clr: got %0d required 1", beat_cnt); end
    wait_drain(50, to);
    n_cmp += 2;
    if (to) begin n_err++; $display("FAIL clr_drain: timed out, %0d outstanding required 0", sb.size()); end
    if (underflow_err !== 1'b0) begin n_err++; $display("FAIL uf_before: got %b required 0", underflow_err); end
    uf_force = 1'b1;
    step();
    uf_force = 1'b0;
    n_cmp++;
    if (underflow_err !== 1'b1) begin n_err++; $display("FAIL uf_set: got %b required 1", underflow_err); end
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (underflow_err !== 1'b1) begin n_err++; $display("FAIL uf_sticky: got %b required 1", underflow_err); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (underflow_err !== 1'b0) begin n_err++; $display("FAIL uf_rst_clear: got %b required 0", underflow_err); end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random_ready();
    test_enable_drop();
    test_async_reset();
    test_counter_and_underflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
